fp_compare_pipe: RTL

Parametrised, pipelined IEEE-754 comparator for any binary format (half, single, double) with full special-value semantics: NaN gives unordered, ±0 compare equal, infinities and subnormals are ordered correctly. It also produces minNum/maxNum results. The block sits on a valid/ready stream between an operand source and a consumer. It sustains one comparison per cycle, applies backpressure, and carries a tag through the pipeline so callers can match results to requests.

---
 rtl/fp_cmp_pkg.sv | 30 +++
 rtl/fp_classify.sv | 34 +++
 rtl/fp_compare_pipe.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/fp_cmp_pkg.sv
// Shared types and helpers for the pipelined IEEE-754 comparator.
// Format width and canonical quiet NaN are derived from the exponent/mantissa widths.
`timescale 1ns/1ps
package fp_cmp_pkg;

  localparam int FP_MAX_W = 128;

  typedef struct packed {
    logic isnan;
    logic isinf;
    logic iszero;
    logic sign;
  } fp_class_t;

  function automatic int fp_w(input int exp_w, input int man_w);
    return 1 + exp_w + man_w;
  endfunction

  // Quiet NaN with positive sign and only the mantissa MSB set.
  function automatic logic [FP_MAX_W-1:0] canon_qnan(input int exp_w, input int man_w);
    logic [FP_MAX_W-1:0] r;
    r = '0;
    for (int i = 0; i < exp_w; i++) begin
      r[man_w+i] = 1'b1;
    end
    r[man_w-1] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/fp_classify.sv
// Combinational classifier: splits one operand into NaN/Inf/zero flags and sign.
`timescale 1ns/1ps
module fp_classify
  import fp_cmp_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  localparam int W = fp_w(EXP_W, MAN_W)
) (
  input  logic [W-1:0] op,
  output fp_class_t    cls
);

  logic [EXP_W-1:0] exp_f;
  logic [MAN_W-1:0] man_f;
  logic             exp_ones;
  logic             exp_zero;
  logic             man_zero;

  assign exp_f    = op[W-2 -: EXP_W];
  assign man_f    = op[MAN_W-1:0];
  assign exp_ones = &exp_f;
  assign exp_zero = ~|exp_f;
  assign man_zero = ~|man_f;

  always_comb begin
    cls        = '0;
    cls.sign   = op[W-1];
    cls.isnan  = exp_ones & ~man_zero;
    cls.isinf  = exp_ones & man_zero;
    cls.iszero = exp_zero & man_zero;
  end

endmodule

// File: rtl/fp_compare_pipe.sv
// Two-stage valid/ready IEEE-754 comparator producing eq/lt/gt/unordered and minNum/maxNum.
// S1 registers classification and magnitude compare; S2 registers the resolved result.
`timescale 1ns/1ps
module fp_compare_pipe
  import fp_cmp_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int TAG_W = 4,
  localparam int W = fp_w(EXP_W, MAN_W)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_a,
  input  logic [W-1:0]     in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_eq,
  output logic             out_lt,
  output logic             out_gt,
  output logic             out_unord,
  output logic [W-1:0]     out_min,
  output logic [W-1:0]     out_max,
  output logic [TAG_W-1:0] out_tag
);

  localparam logic [FP_MAX_W-1:0] QNAN_WIDE = canon_qnan(EXP_W, MAN_W);
  localparam logic [W-1:0]        QNAN      = QNAN_WIDE[W-1:0];

  fp_class_t        cls_a;
  fp_class_t        cls_b;

  logic             s1_valid;
  fp_class_t        s1_cls_a;
  fp_class_t        s1_cls_b;
  logic             s1_mag_gt;
  logic             s1_mag_eq;
  logic [W-1:0]     s1_a;
  logic [W-1:0]     s1_b;
  logic [TAG_W-1:0] s1_tag;

  logic             s2_valid;
  logic             s2_eq;
  logic             s2_lt;
  logic             s2_gt;
  logic             s2_unord;
  logic [W-1:0]     s2_min;
  logic [W-1:0]     s2_max;
  logic [TAG_W-1:0] s2_tag;

  logic             s2_load;
  logic             in_fire;
  logic             mag_lt;
  logic             inf_match;
  logic             r_eq;
  logic             r_lt;
  logic             r_gt;
  logic             r_unord;
  logic [W-1:0]     r_min;
  logic [W-1:0]     r_max;

  fp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_class_a (.op(in_a), .cls(cls_a));
  fp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_class_b (.op(in_b), .cls(cls_b));

  // Backpressure ripples combinationally from out_ready to in_ready; there is no skid buffer.
  assign s2_load  = s1_valid & (~s2_valid | out_ready);
  assign in_ready = ~rst & (~s1_valid | s2_load);
  assign in_fire  = in_valid & in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_cls_a  <= '0;
      s1_cls_b  <= '0;
      s1_mag_gt <= 1'b0;
      s1_mag_eq <= 1'b0;
      s1_a      <= '0;
      s1_b      <= '0;
      s1_tag    <= '0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_fire) begin
        s1_cls_a  <= cls_a;
        s1_cls_b  <= cls_b;
        s1_mag_gt <= in_a[W-2:0] > in_b[W-2:0];
        s1_mag_eq <= in_a[W-2:0] == in_b[W-2:0];
        s1_a      <= in_a;
        s1_b      <= in_b;
        s1_tag    <= in_tag;
      end
    end
  end

  assign mag_lt    = ~s1_mag_gt & ~s1_mag_eq;
  assign inf_match = s1_cls_a.isinf & s1_cls_b.isinf;

  // Relation flags: negative operands with equal signs swap the magnitude ordering.
  always_comb begin
    r_unord = s1_cls_a.isnan | s1_cls_b.isnan;
    r_eq    = 1'b0;
    r_lt    = 1'b0;
    r_gt    = 1'b0;
    if (!r_unord) begin
      if (s1_cls_a.iszero && s1_cls_b.iszero) begin
        r_eq = 1'b1;
      end else if (s1_cls_a.sign != s1_cls_b.sign) begin
        r_gt = ~s1_cls_a.sign;
        r_lt = s1_cls_a.sign;
      end else begin
        r_eq = s1_mag_eq | inf_match;
        r_gt = s1_cls_a.sign ? mag_lt : s1_mag_gt;
        r_lt = s1_cls_a.sign ? s1_mag_gt : mag_lt;
      end
    end
  end

  // minNum/maxNum: a single NaN yields the other operand; equal values merge signs so -0 < +0.
  always_comb begin
    r_min = s1_a;
    r_max = s1_b;
    if (s1_cls_a.isnan && s1_cls_b.isnan) begin
      r_min = QNAN;
      r_max = QNAN;
    end else if (s1_cls_a.isnan) begin
      r_min = s1_b;
      r_max = s1_b;
    end else if (s1_cls_b.isnan) begin
      r_min = s1_a;
      r_max = s1_a;
    end else if (r_eq) begin
      r_min = {s1_a[W-1] | s1_b[W-1], s1_a[W-2:0]};
      r_max = {s1_a[W-1] & s1_b[W-1], s1_a[W-2:0]};
    end else if (r_gt) begin
      r_min = s1_b;
      r_max = s1_a;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_eq    <= 1'b0;
      s2_lt    <= 1'b0;
      s2_gt    <= 1'b0;
      s2_unord <= 1'b0;
      s2_min   <= '0;
      s2_max   <= '0;
      s2_tag   <= '0;
    end else if (s2_load) begin
      s2_valid <= 1'b1;
      s2_eq    <= r_eq;
      s2_lt    <= r_lt;
      s2_gt    <= r_gt;
      s2_unord <= r_unord;
      s2_min   <= r_min;
      s2_max   <= r_max;
      s2_tag   <= s1_tag;
    end else if (out_ready) begin
      s2_valid <= 1'b0;
    end
  end

  assign out_valid = s2_valid;
  assign out_eq    = s2_eq;
  assign out_lt    = s2_lt;
  assign out_gt    = s2_gt;
  assign out_unord = s2_unord;
  assign out_min   = s2_min;
  assign out_max   = s2_max;
  assign out_tag   = s2_tag;

endmodule
